// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with operand forwarding, immediate sign-extension and load-use stall
module id_ex_stage #(
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          id_valid,
  input  logic [DW-1:0] id_instr,
  input  logic [DW-1:0] rf_rdata1,
  input  logic [DW-1:0] rf_rdata2,
  input  logic          FORWARD_OP1_MUX,
  input  logic          FORWARD_OP2_MUX,
  input  logic [DW-1:0] fw_op1,
  input  logic [DW-1:0] fw_op2,
  input  logic          flush,
  output logic          stall,
  output logic          ex_valid,
  output logic [DW-1:0] ex_instr,
  output logic [DW-1:0] ex_op1,
  output logic [DW-1:0] ex_op2,
  output logic [DW-1:0] ex_wdata,
  output logic [2:0]    ex_dest,
  output logic          ex_we,
  output logic          ex_mem_rd,
  output logic          ex_mem_wr
);

  typedef enum logic {RUN, BUBBLE} state_t;

  state_t state_q, state_d;

  logic [3:0]    op;
  logic [2:0]    rs, rt, rd;
  logic [DW-1:0] rs_val, rt_val, imm_sext;

  assign op       = id_instr[15:12];
  assign rs       = id_instr[11:9];
  assign rt       = id_instr[8:6];
  assign rd       = id_instr[5:3];
  assign rs_val   = FORWARD_OP1_MUX ? fw_op1 : rf_rdata1;
  assign rt_val   = FORWARD_OP2_MUX ? fw_op2 : rf_rdata2;
  assign imm_sext = {{(DW-6){id_instr[5]}}, id_instr[5:0]};

  logic          d_we, d_mem_rd, d_mem_wr, use_rs, use_rt;
  logic [2:0]    d_dest;
  logic [DW-1:0] d_op1, d_op2;

  always_comb begin
    d_we     = 1'b0;
    d_mem_rd = 1'b0;
    d_mem_wr = 1'b0;
    d_dest   = 3'd0;
    d_op1    = rs_val;
    d_op2    = rt_val;
    use_rs   = 1'b0;
    use_rt   = 1'b0;
    case (op)
      4'd0: begin
        use_rs = 1'b1; use_rt = 1'b1; d_dest = rd; d_we = 1'b1;
      end
      4'd1, 4'd3: begin
        use_rt = 1'b1; d_dest = rs; d_we = 1'b1;
        d_op1  = rt_val; d_op2 = imm_sext;
      end
      4'd4: begin
        use_rs = 1'b1; d_dest = rt; d_we = 1'b1; d_mem_rd = 1'b1;
        d_op2  = imm_sext;
      end
      4'd5: begin
        use_rs = 1'b1; use_rt = 1'b1; d_mem_wr = 1'b1;
        d_op2  = imm_sext;
      end
      4'd6: begin
        use_rs = 1'b1; use_rt = 1'b1;
      end
      default: ;
    endcase
  end

  // r0 is deliberately not excluded from the compare
  logic hz;
  assign hz = id_valid & ex_valid & ex_mem_rd &
              ((use_rs & (ex_dest == rs)) | (use_rt & (ex_dest == rt)));

  logic load_id;

  always_comb begin
    state_d = state_q;
    stall   = 1'b0;
    load_id = 1'b0;
    case (state_q)
      RUN: begin
        if (flush) begin
          state_d = RUN;
        end else if (hz) begin
          stall   = 1'b1;
          state_d = BUBBLE;
        end else begin
          load_id = id_valid;
        end
      end
      BUBBLE: begin
        state_d = RUN;
        load_id = id_valid & ~flush;
      end
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= RUN;
      ex_valid  <= 1'b0;
      ex_instr  <= '0;
      ex_op1    <= '0;
      ex_op2    <= '0;
      ex_wdata  <= '0;
      ex_dest   <= 3'd0;
      ex_we     <= 1'b0;
      ex_mem_rd <= 1'b0;
      ex_mem_wr <= 1'b0;
    end else begin
      state_q <= state_d;
      if (load_id) begin
        ex_valid  <= 1'b1;
        ex_instr  <= id_instr;
        ex_op1    <= d_op1;
        ex_op2    <= d_op2;
        ex_wdata  <= rt_val;
        ex_dest   <= d_dest;
        ex_we     <= d_we;
        ex_mem_rd <= d_mem_rd;
        ex_mem_wr <= d_mem_wr;
      end else begin
        ex_valid  <= 1'b0;
        ex_instr  <= '0;
        ex_op1    <= '0;
        ex_op2    <= '0;
        ex_wdata  <= '0;
        ex_dest   <= 3'd0;
        ex_we     <= 1'b0;
        ex_mem_rd <= 1'b0;
        ex_mem_wr <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - directed self-checking bench for id_ex_stage
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [15:0] id_instr;
  logic [15:0] rf_rdata1, rf_rdata2, fw_op1, fw_op2;
  logic        FORWARD_OP1_MUX, FORWARD_OP2_MUX, flush;
  logic        stall, ex_valid, ex_we, ex_mem_rd, ex_mem_wr;
  logic [15:0] ex_instr, ex_op1, ex_op2, ex_wdata;
  logic [2:0]  ex_dest;

  int n_checks = 0;
  int n_fail   = 0;

  id_ex_stage #(.DW(16)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_instr(id_instr),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .FORWARD_OP1_MUX(FORWARD_OP1_MUX), .FORWARD_OP2_MUX(FORWARD_OP2_MUX),
    .fw_op1(fw_op1), .fw_op2(fw_op2), .flush(flush), .stall(stall),
    .ex_valid(ex_valid), .ex_instr(ex_instr), .ex_op1(ex_op1), .ex_op2(ex_op2),
    .ex_wdata(ex_wdata), .ex_dest(ex_dest), .ex_we(ex_we),
    .ex_mem_rd(ex_mem_rd), .ex_mem_wr(ex_mem_wr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_bubble(input string tag);
    chk({tag, "_valid"}, 16'(ex_valid), 16'h0);
    chk({tag, "_instr"}, ex_instr, 16'h0);
    chk({tag, "_op1"},   ex_op1, 16'h0);
    chk({tag, "_op2"},   ex_op2, 16'h0);
    chk({tag, "_wdata"}, ex_wdata, 16'h0);
    chk({tag, "_dest"},  16'(ex_dest), 16'h0);
    chk({tag, "_we"},    16'(ex_we), 16'h0);
    chk({tag, "_mrd"},   16'(ex_mem_rd), 16'h0);
    chk({tag, "_mwr"},   16'(ex_mem_wr), 16'h0);
  endtask

  task automatic set_id(input logic v, input logic [15:0] ins);
    id_valid = v;
    id_instr = ins;
  endtask

  initial begin
    rst = 1'b0;
    set_id(1'b0, 16'h0);
    rf_rdata1 = 16'h0; rf_rdata2 = 16'h0; fw_op1 = 16'h0; fw_op2 = 16'h0;
    FORWARD_OP1_MUX = 1'b0; FORWARD_OP2_MUX = 1'b0; flush = 1'b0;
    #1;
    chk_bubble("rst0");
    chk("rst0_stall", 16'(stall), 16'h0);
    step(); step();
    rst = 1'b1;

    // R add r3 = r1 + r2 (0x0298)
    set_id(1'b1, 16'h0298); rf_rdata1 = 16'h0005; rf_rdata2 = 16'h0007;
    #1 chk("add_stall", 16'(stall), 16'h0);
    step();
    chk("add_valid", 16'(ex_valid), 16'h1);
    chk("add_instr", ex_instr, 16'h0298);
    chk("add_op1", ex_op1, 16'h0005);
    chk("add_op2", ex_op2, 16'h0007);
    chk("add_dest", 16'(ex_dest), 16'h3);
    chk("add_we", 16'(ex_we), 16'h1);

    // forwarded rt
    FORWARD_OP2_MUX = 1'b1; fw_op2 = 16'h00AA;
    step();
    chk("fw2_op2", ex_op2, 16'h00AA);
    chk("fw2_op1", ex_op1, 16'h0005);
    FORWARD_OP2_MUX = 1'b0;

    // addi rs=1 rt=2 imm=0x3C (0x12BC): op1 = rt value, dest = rs
    set_id(1'b1, 16'h12BC); rf_rdata2 = 16'h0011;
    step();
    chk("addi_op1", ex_op1, 16'h0011);
    chk("addi_op2", ex_op2, 16'hFFFC);
    chk("addi_dest", 16'(ex_dest), 16'h1);
    chk("addi_we", 16'(ex_we), 16'h1);

    // load-use: lw r2 (0x4284) then add rs=2 rt=3 rd=4 (0x04E0)
    set_id(1'b1, 16'h4284); rf_rdata1 = 16'h0100;
    step();
    chk("lw_mrd", 16'(ex_mem_rd), 16'h1);
    chk("lw_dest", 16'(ex_dest), 16'h2);
    chk("lw_op2", ex_op2, 16'h0004);
    set_id(1'b1, 16'h04E0); rf_rdata1 = 16'hDEAD; rf_rdata2 = 16'h0003;
    #1 chk("lu_stall", 16'(stall), 16'h1);
    step();
    chk_bubble("lu_bub");
    chk("lu_stall_bub", 16'(stall), 16'h0);
    rf_rdata1 = 16'h1234;
    step();
    chk("lu_instr", ex_instr, 16'h04E0);
    chk("lu_valid", 16'(ex_valid), 16'h1);
    chk("lu_op1", ex_op1, 16'h1234);
    chk("lu_dest", 16'(ex_dest), 16'h4);
    chk("lu_stall_after", 16'(stall), 16'h0);

    // flush arriving in BUBBLE
    set_id(1'b1, 16'h4284);
    step();
    set_id(1'b1, 16'h04E0);
    #1 chk("fl_stall", 16'(stall), 16'h1);
    step();
    flush = 1'b1;
    #1 chk("fl_stall_bub", 16'(stall), 16'h0);
    step();
    flush = 1'b0;
    chk_bubble("fl_bub");
    set_id(1'b1, 16'h0298); rf_rdata1 = 16'h0005; rf_rdata2 = 16'h0007;
    #1 chk("fl_stall_run", 16'(stall), 16'h0);
    step();
    chk("fl_next_instr", ex_instr, 16'h0298);
    chk("fl_next_valid", 16'(ex_valid), 16'h1);

    // flush in RUN kills the entering instruction
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk_bubble("flrun");

    // r0 participates in the hazard compare: lw r0 (0x4204) then R rs=0 (0x0098)
    set_id(1'b1, 16'h4204);
    step();
    set_id(1'b1, 16'h0098);
    #1 chk("r0_stall", 16'(stall), 16'h1);
    step();
    chk("r0_bub_valid", 16'(ex_valid), 16'h0);
    step();
    chk("r0_instr", ex_instr, 16'h0098);

    // asynchronous reset mid-stall
    set_id(1'b1, 16'h4284);
    step();
    set_id(1'b1, 16'h04E0);
    #1 chk("ar_stall_pre", 16'(stall), 16'h1);
    #2 rst = 1'b0;
    #1;
    chk_bubble("ar");
    chk("ar_stall", 16'(stall), 16'h0);
    #1 rst = 1'b1;
    set_id(1'b1, 16'h0298);
    step();
    chk("ar_rel_instr", ex_instr, 16'h0298);
    chk("ar_rel_valid", 16'(ex_valid), 16'h1);

    // sw rs=1 rt=4 imm=2 (0x5302) with rs forwarded
    set_id(1'b1, 16'h5302); rf_rdata1 = 16'h0033; rf_rdata2 = 16'h4444;
    FORWARD_OP1_MUX = 1'b1; fw_op1 = 16'h0100;
    step();
    chk("sw_op1", ex_op1, 16'h0100);
    chk("sw_op2", ex_op2, 16'h0002);
    chk("sw_wdata", ex_wdata, 16'h4444);
    chk("sw_mwr", 16'(ex_mem_wr), 16'h1);
    chk("sw_we", 16'(ex_we), 16'h0);
    FORWARD_OP1_MUX = 1'b0;

    // invalid ID slot yields a bubble
    set_id(1'b0, 16'h0298);
    step();
    chk("inv_valid", 16'(ex_valid), 16'h0);
    chk("inv_instr", ex_instr, 16'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
